// File: rtl/ifu_fetch.sv
// ifu_fetch -- instruction fetch unit of the NPC core.
//
// Holds the architectural PC and fetches one 32-bit instruction at a time
// from instruction memory. The fetched word is presented to the decoder
// together with its PC and a fault flag. Redirects from the branch/jump
// path replace the PC, and any fetch already in flight is squashed.
//
// Ports:
//   clk, rst_n                      core clock, synchronous active-low reset
//   imem_req_valid/ready/addr       fetch request to instruction memory
//   imem_rsp_valid/data/err         fetch response (err = access fault)
//   inst_valid/ready                handshake with the decoder
//   instruction, inst_pc, inst_fault  presented instruction and attributes
//   redirect_valid, redirect_pc     next-PC override from branch/jump path
//   fetch_cnt                       count of instructions consumed by decoder
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        imem_rsp_err,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] instruction,
  output logic [31:0] inst_pc,
  output logic        inst_fault,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] fetch_cnt
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

  state_t      state;
  logic [31:0] pc;
  logic        squash;     // response of the outstanding request must be dropped
  logic        pc_aligned;

  assign pc_aligned     = (pc[1:0] == 2'b00);
  // A misaligned PC never reaches memory; it is turned into a fault instead.
  assign imem_req_valid = (state == REQ) && pc_aligned;
  assign imem_req_addr  = pc;
  assign inst_valid     = (state == HOLD);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      squash      <= 1'b0;
      instruction <= NOP_INST;
      inst_pc     <= RESET_PC;
      inst_fault  <= 1'b0;
      fetch_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (redirect_valid) pc <= redirect_pc;
          state <= REQ;
        end

        REQ: begin
          if (redirect_valid) begin
            // The new target wins over a pending misalignment fault; the
            // fault is re-evaluated against the new PC next cycle.
            pc <= redirect_pc;
            if (imem_req_valid && imem_req_ready) begin
              squash <= 1'b1;
              state  <= WAIT;
            end
          end else if (!pc_aligned) begin
            instruction <= NOP_INST;
            inst_pc     <= pc;
            inst_fault  <= 1'b1;
            state       <= HOLD;
          end else if (imem_req_ready) begin
            state <= WAIT;
          end
        end

        WAIT: begin
          if (redirect_valid) pc <= redirect_pc;
          if (imem_rsp_valid) begin
            if (squash || redirect_valid) begin
              // Stale response: drop it and refetch from the current PC.
              squash <= 1'b0;
              state  <= REQ;
            end else begin
              instruction <= imem_rsp_err ? NOP_INST : imem_rsp_data;
              inst_fault  <= imem_rsp_err;
              inst_pc     <= pc;
              state       <= HOLD;
            end
          end else if (redirect_valid) begin
            squash <= 1'b1;
          end
        end

        HOLD: begin
          if (inst_ready) begin
            fetch_cnt <= fetch_cnt + 32'd1;
            pc        <= redirect_valid ? redirect_pc : pc + 32'd4;
            state     <= REQ;
          end else if (redirect_valid) begin
            // Held instruction is on the wrong path: drop it uncounted.
            pc    <= redirect_pc;
            state <= REQ;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
module tb_ifu_fetch;

  localparam logic [31:0] A   = 32'h8000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Main DUT (default RESET_PC)
  logic        rst_n, req_ready, rsp_valid, rsp_err, inst_ready, redir;
  logic [31:0] rsp_data, redir_pc;
  logic        req_valid, inst_valid, inst_fault;
  logic [31:0] req_addr, instruction, inst_pc, fetch_cnt;

  ifu_fetch dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(req_valid), .imem_req_ready(req_ready), .imem_req_addr(req_addr),
    .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data), .imem_rsp_err(rsp_err),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .instruction(instruction),
    .inst_pc(inst_pc), .inst_fault(inst_fault),
    .redirect_valid(redir), .redirect_pc(redir_pc), .fetch_cnt(fetch_cnt)
  );

  // Second DUT for PC wrap-around
  logic        w_rst_n, w_req_ready, w_rsp_valid, w_rsp_err, w_inst_ready, w_redir;
  logic [31:0] w_rsp_data, w_redir_pc;
  logic        w_req_valid, w_inst_valid, w_inst_fault;
  logic [31:0] w_req_addr, w_instruction, w_inst_pc, w_fetch_cnt;

  ifu_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst_n(w_rst_n),
    .imem_req_valid(w_req_valid), .imem_req_ready(w_req_ready), .imem_req_addr(w_req_addr),
    .imem_rsp_valid(w_rsp_valid), .imem_rsp_data(w_rsp_data), .imem_rsp_err(w_rsp_err),
    .inst_valid(w_inst_valid), .inst_ready(w_inst_ready), .instruction(w_instruction),
    .inst_pc(w_inst_pc), .inst_fault(w_inst_fault),
    .redirect_valid(w_redir), .redirect_pc(w_redir_pc), .fetch_cnt(w_fetch_cnt)
  );

  typedef struct {
    logic        rst_n, rdy, rv;
    logic [31:0] rd;
    logic        re, ir, redir;
    logic [31:0] rpc;
    logic        e_rv;
    logic [31:0] e_ra;
    logic        e_iv;
    logic [31:0] e_ins, e_ipc;
    logic        e_flt;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vecs[$];
  int checks   = 0;
  int failures = 0;

  task automatic add(input logic r, input logic rdy, input logic rv, input logic [31:0] rd,
                     input logic re, input logic ir, input logic rdr, input logic [31:0] rpc,
                     input logic e_rv, input logic [31:0] e_ra, input logic e_iv,
                     input logic [31:0] e_ins, input logic [31:0] e_ipc, input logic e_flt,
                     input logic [31:0] e_cnt);
    vec_t v;
    v.rst_n = r; v.rdy = rdy; v.rv = rv; v.rd = rd; v.re = re; v.ir = ir;
    v.redir = rdr; v.rpc = rpc; v.e_rv = e_rv; v.e_ra = e_ra; v.e_iv = e_iv;
    v.e_ins = e_ins; v.e_ipc = e_ipc; v.e_flt = e_flt; v.e_cnt = e_cnt;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  initial begin
    rst_n = 0; req_ready = 0; rsp_valid = 0; rsp_data = 0; rsp_err = 0;
    inst_ready = 0; redir = 0; redir_pc = 0;
    w_rst_n = 0; w_req_ready = 0; w_rsp_valid = 0; w_rsp_data = 0; w_rsp_err = 0;
    w_inst_ready = 0; w_redir = 0; w_redir_pc = 0;

    // reset and first fetch with a 1-cycle memory
    add(0,0,0,0,0,0,0,0,              0,A,0,NOP,A,0,0);
    add(0,0,0,0,0,0,0,0,              0,A,0,NOP,A,0,0);
    add(1,0,0,0,0,0,0,0,              1,A,0,NOP,A,0,0);
    add(1,1,0,0,0,0,0,0,              0,A,0,NOP,A,0,0);
    add(1,0,1,32'h00500093,0,0,0,0,   0,A,1,32'h00500093,A,0,0);
    // decoder stalls 5 cycles; a stray response in HOLD is ignored
    for (int i = 0; i < 5; i++)
      add(1,i[0],(i == 2),32'hBAD0_0BAD,0,0,0,0, 0,A,1,32'h00500093,A,0,0);
    add(1,0,0,0,0,1,0,0,              1,A+4,0,32'h00500093,A,0,1);
    // memory not ready for 3 cycles, response 2 cycles after acceptance
    for (int i = 0; i < 3; i++)
      add(1,0,0,0,0,0,0,0,            1,A+4,0,32'h00500093,A,0,1);
    add(1,1,0,0,0,0,0,0,              0,A+4,0,32'h00500093,A,0,1);
    add(1,0,0,0,0,0,0,0,              0,A+4,0,32'h00500093,A,0,1);
    add(1,0,1,32'h00100113,0,0,0,0,   0,A+4,1,32'h00100113,A+4,0,1);
    add(1,0,0,0,0,1,0,0,              1,A+8,0,32'h00100113,A+4,0,2);
    // redirect during WAIT, stale response discarded
    add(1,1,0,0,0,0,0,0,              0,A+8,0,32'h00100113,A+4,0,2);
    add(1,0,0,0,0,0,1,A+32'h100,      0,A+32'h100,0,32'h00100113,A+4,0,2);
    add(1,0,1,32'hDEADBEEF,0,0,0,0,   1,A+32'h100,0,32'h00100113,A+4,0,2);
    add(1,1,0,0,0,0,0,0,              0,A+32'h100,0,32'h00100113,A+4,0,2);
    add(1,0,1,32'h00000073,0,0,0,0,   0,A+32'h100,1,32'h00000073,A+32'h100,0,2);
    // access fault
    add(1,0,0,0,0,1,0,0,              1,A+32'h104,0,32'h00000073,A+32'h100,0,3);
    add(1,1,0,0,0,0,0,0,              0,A+32'h104,0,32'h00000073,A+32'h100,0,3);
    add(1,0,1,32'h12345678,1,0,0,0,   0,A+32'h104,1,NOP,A+32'h104,1,3);
    // consume with redirect to a misaligned target
    add(1,0,0,0,0,1,1,A+32'h102,      0,A+32'h102,0,NOP,A+32'h104,1,4);
    add(1,1,0,0,0,0,0,0,              0,A+32'h102,1,NOP,A+32'h102,1,4);
    // redirect in HOLD without consumption drops the instruction
    add(1,0,0,0,0,0,1,A+32'h200,      1,A+32'h200,0,NOP,A+32'h102,1,4);
    // redirect in the accepting REQ cycle squashes the response
    add(1,1,0,0,0,0,1,A+32'h300,      0,A+32'h300,0,NOP,A+32'h102,1,4);
    add(1,0,1,32'hAAAA5555,0,0,0,0,   1,A+32'h300,0,NOP,A+32'h102,1,4);
    // reset during WAIT
    add(1,1,0,0,0,0,0,0,              0,A+32'h300,0,NOP,A+32'h102,1,4);
    add(0,0,0,0,0,0,0,0,              0,A,0,NOP,A,0,0);
    add(1,0,0,0,0,0,0,0,              1,A,0,NOP,A,0,0);
    // redirect and response in the same WAIT cycle leave squash clear
    add(1,1,0,0,0,0,0,0,              0,A,0,NOP,A,0,0);
    add(1,0,1,32'h0BAD0BAD,0,0,1,A+32'h40, 1,A+32'h40,0,NOP,A,0,0);
    add(1,1,0,0,0,0,0,0,              0,A+32'h40,0,NOP,A,0,0);
    add(1,0,1,32'h00200193,0,0,0,0,   0,A+32'h40,1,32'h00200193,A+32'h40,0,0);
    add(1,0,0,0,0,1,0,0,              1,A+32'h44,0,32'h00200193,A+32'h40,0,1);

    #1;
    foreach (vecs[i]) begin
      rst_n = vecs[i].rst_n; req_ready = vecs[i].rdy; rsp_valid = vecs[i].rv;
      rsp_data = vecs[i].rd; rsp_err = vecs[i].re; inst_ready = vecs[i].ir;
      redir = vecs[i].redir; redir_pc = vecs[i].rpc;
      @(posedge clk); #1;
      chk("req_valid",   i, {31'd0, req_valid},  {31'd0, vecs[i].e_rv});
      chk("req_addr",    i, req_addr,            vecs[i].e_ra);
      chk("inst_valid",  i, {31'd0, inst_valid}, {31'd0, vecs[i].e_iv});
      chk("instruction", i, instruction,         vecs[i].e_ins);
      chk("inst_pc",     i, inst_pc,             vecs[i].e_ipc);
      chk("inst_fault",  i, {31'd0, inst_fault}, {31'd0, vecs[i].e_flt});
      chk("fetch_cnt",   i, fetch_cnt,           vecs[i].e_cnt);
    end

    // PC wrap-around: RESET_PC = 0xFFFF_FFFC
    w_rst_n = 0;
    @(posedge clk); #1;
    chk("wrap_reset_addr", 0, w_req_addr, 32'hFFFF_FFFC);
    chk("wrap_reset_valid", 0, {31'd0, w_req_valid}, 32'd0);
    w_rst_n = 1;
    @(posedge clk); #1;
    chk("wrap_req_valid", 1, {31'd0, w_req_valid}, 32'd1);
    chk("wrap_req_addr",  1, w_req_addr, 32'hFFFF_FFFC);
    w_req_ready = 1;
    @(posedge clk); #1;
    w_req_ready = 0; w_rsp_valid = 1; w_rsp_data = 32'h00300213;
    @(posedge clk); #1;
    w_rsp_valid = 0;
    chk("wrap_inst_valid", 3, {31'd0, w_inst_valid}, 32'd1);
    chk("wrap_inst",       3, w_instruction, 32'h00300213);
    chk("wrap_inst_pc",    3, w_inst_pc, 32'hFFFF_FFFC);
    w_inst_ready = 1;
    @(posedge clk); #1;
    w_inst_ready = 0;
    chk("wrap_next_addr",  4, w_req_addr, 32'h0000_0000);
    chk("wrap_next_valid", 4, {31'd0, w_req_valid}, 32'd1);
    chk("wrap_cnt",        4, w_fetch_cnt, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
